// File: rtl/yzh_vektor_carpim_birimi.sv
// yzh_vektor_carpim_birimi
// Dot-product unit for the execute stage. It holds separate W and X buffers
// and computes sum(W[i]*X[i]) for i < min(count_w, count_x) using its own
// pipelined multiply-accumulate, so the core's shared multiplier stays free.
// Optional build macro: YZH_DOYMA_EN. When it is defined, full-width products
// are accumulated and the result is clamped to the signed output range.
// When it is undefined, the low product bits are accumulated with wrap-around.
//
// state   | meaning
// BOSTA   | idle; commands are accepted here
// HESAPLA | issuing one W/X pair per cycle into the multiplier pipeline
// BOSALT  | draining the pipeline, then publishing the result

module yzh_vektor_carpim_birimi #(
  parameter int VERI_GENISLIGI   = 32,
  parameter int DERINLIK         = 16,
  parameter int CARPMA_GECIKMESI = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ddb_durdur_i,
  input  logic [2:0]                kontrol_i,
  input  logic                      basla_i,
  input  logic                      rs2_en_i,
  input  logic [VERI_GENISLIGI-1:0] deger1_i,
  input  logic [VERI_GENISLIGI-1:0] deger2_i,
  output logic [VERI_GENISLIGI-1:0] sonuc_o,
  output logic                      bitti_o,
  output logic                      mesgul_o,
  output logic                      w_dolu_o,
  output logic                      x_dolu_o
);

  // Command encodings, matching the core's definitions header.
  localparam logic [2:0] YZH_LD_W  = 3'd0;
  localparam logic [2:0] YZH_LD_X  = 3'd1;
  localparam logic [2:0] YZH_CLR_W = 3'd2;
  localparam logic [2:0] YZH_CLR_X = 3'd3;
  localparam logic [2:0] YZH_RUN   = 3'd4;

  localparam int VG = VERI_GENISLIGI;
  localparam int L  = CARPMA_GECIKMESI;
  localparam int AI = $clog2(DERINLIK);
  localparam int CW = AI + 1;
  localparam int BW = $clog2(CARPMA_GECIKMESI + 1);
`ifdef YZH_DOYMA_EN
  localparam int PW = 2 * VG;
  localparam int AW = PW + AI;
`else
  localparam int PW = VG;
  localparam int AW = VG;
`endif

  localparam logic [CW-1:0] DOLU       = CW'(DERINLIK);
  localparam logic [BW-1:0] BOSALT_BAS = BW'(CARPMA_GECIKMESI);

  typedef enum logic [1:0] {BOSTA, HESAPLA, BOSALT} durum_t;

  durum_t durum_q, durum_d;

  logic [VG-1:0] w_mem [DERINLIK];
  logic [VG-1:0] x_mem [DERINLIK];

  logic [CW-1:0]        sayac_w_q, sayac_w_d, sayac_x_q, sayac_x_d;
  logic [AI-1:0]        idx_q, idx_d;
  logic [CW-1:0]        n_q, n_d;
  logic [BW-1:0]        bosalt_q, bosalt_d;
  logic [L-1:0]         gecerli_q, gecerli_d;
  logic [PW-1:0]        boru_q [L];
  logic signed [AW-1:0] acc_q, acc_d;
  logic [VG-1:0]        sonuc_q, sonuc_d;
  logic                 bitti_q, bitti_d;

  logic                 kabul, run_kabul, hesapla_aktif, bitir;
  logic [CW-1:0]        n_kucuk;
  logic [CW:0]          w_art, x_art;
  logic                 w_yaz1, w_yaz2, x_yaz1, x_yaz2;
  logic signed [VG-1:0] w_oku, x_oku;
  logic signed [PW-1:0] carpim;
  logic signed [AW-1:0] eklenen;
  logic [VG-1:0]        kirpik;

  assign kabul     = basla_i & ~ddb_durdur_i & ~rst_i & (durum_q == BOSTA);
  assign run_kabul = kabul & (kontrol_i == YZH_RUN);
  assign n_kucuk   = (sayac_w_q < sayac_x_q) ? sayac_w_q : sayac_x_q;

  // Load bookkeeping: second word only lands if a slot remains after the first.
  assign w_art  = {1'b0, sayac_w_q} + (CW+1)'(1) + (CW+1)'(rs2_en_i);
  assign x_art  = {1'b0, sayac_x_q} + (CW+1)'(1) + (CW+1)'(rs2_en_i);
  assign w_yaz1 = kabul & (kontrol_i == YZH_LD_W) & (sayac_w_q < DOLU);
  assign x_yaz1 = kabul & (kontrol_i == YZH_LD_X) & (sayac_x_q < DOLU);
  assign w_yaz2 = w_yaz1 & rs2_en_i & (({1'b0, sayac_w_q} + (CW+1)'(1)) < {1'b0, DOLU});
  assign x_yaz2 = x_yaz1 & rs2_en_i & (({1'b0, sayac_x_q} + (CW+1)'(1)) < {1'b0, DOLU});

  assign w_oku = w_mem[idx_q];
  assign x_oku = x_mem[idx_q];
  assign carpim = w_oku * x_oku;

`ifdef YZH_DOYMA_EN
  localparam logic signed [AW-1:0] UST = {{(AW-VG+1){1'b0}}, {(VG-1){1'b1}}};
  localparam logic signed [AW-1:0] ALT = {{(AW-VG+1){1'b1}}, {(VG-1){1'b0}}};
  assign eklenen = {{AI{boru_q[L-1][PW-1]}}, boru_q[L-1]};
  assign kirpik  = (acc_q > UST) ? UST[VG-1:0] :
                   (acc_q < ALT) ? ALT[VG-1:0] : acc_q[VG-1:0];
`else
  assign eklenen = boru_q[L-1];
  assign kirpik  = acc_q;
`endif

  // State register; a stall freezes the sequencer.
  always_ff @(posedge clk_i) begin
    if (rst_i)              durum_q <= BOSTA;
    else if (!ddb_durdur_i) durum_q <= durum_d;
  end

  // Next-state logic; an empty RUN goes straight to the final drain cycle.
  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      BOSTA:   if (run_kabul) durum_d = (n_kucuk != '0) ? HESAPLA : BOSALT;
      HESAPLA: if (({1'b0, idx_q} + CW'(1)) == n_q) durum_d = BOSALT;
      BOSALT:  if (bosalt_q == '0) durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    mesgul_o      = (durum_q != BOSTA);
    hesapla_aktif = (durum_q == HESAPLA);
    bitir         = (durum_q == BOSALT) && (bosalt_q == '0);
  end

  // Next values of counts, issue index, drain timer, accumulator and result.
  always_comb begin
    sayac_w_d = sayac_w_q;
    sayac_x_d = sayac_x_q;
    idx_d     = idx_q;
    n_d       = n_q;
    bosalt_d  = bosalt_q;
    acc_d     = acc_q;
    sonuc_d   = sonuc_q;
    bitti_d   = 1'b0;
    gecerli_d[0] = hesapla_aktif;
    for (int s = 1; s < L; s++) gecerli_d[s] = gecerli_q[s-1];

    if (kabul && kontrol_i == YZH_LD_W)
      sayac_w_d = (w_art > {1'b0, DOLU}) ? DOLU : w_art[CW-1:0];
    else if (kabul && kontrol_i == YZH_CLR_W)
      sayac_w_d = '0;
    if (kabul && kontrol_i == YZH_LD_X)
      sayac_x_d = (x_art > {1'b0, DOLU}) ? DOLU : x_art[CW-1:0];
    else if (kabul && kontrol_i == YZH_CLR_X)
      sayac_x_d = '0;

    if (hesapla_aktif) idx_d = idx_q + AI'(1);
    if (durum_q == BOSALT && bosalt_q != '0) bosalt_d = bosalt_q - BW'(1);
    if (gecerli_q[L-1]) acc_d = acc_q + eklenen;

    if (run_kabul) begin
      idx_d    = '0;
      n_d      = n_kucuk;
      bosalt_d = (n_kucuk != '0) ? BOSALT_BAS : '0;
      acc_d    = '0;
    end

    if (bitir) begin
      sonuc_d = kirpik;
      bitti_d = 1'b1;
    end
    if (kabul && kontrol_i != YZH_RUN) bitti_d = 1'b1;
  end

  // Control and result registers; everything holds while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sayac_w_q <= '0;
      sayac_x_q <= '0;
      idx_q     <= '0;
      n_q       <= '0;
      bosalt_q  <= '0;
      gecerli_q <= '0;
      acc_q     <= '0;
      sonuc_q   <= '0;
      bitti_q   <= 1'b0;
    end else if (!ddb_durdur_i) begin
      sayac_w_q <= sayac_w_d;
      sayac_x_q <= sayac_x_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      bosalt_q  <= bosalt_d;
      gecerli_q <= gecerli_d;
      acc_q     <= acc_d;
      sonuc_q   <= sonuc_d;
      bitti_q   <= bitti_d;
    end
  end

  // Multiplier pipeline data; qualified by gecerli_q, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (!ddb_durdur_i) begin
      boru_q[0] <= carpim;
      for (int s = 1; s < L; s++) boru_q[s] <= boru_q[s-1];
    end
  end

  // Buffer writes; kabul already excludes stall and reset.
  always_ff @(posedge clk_i) begin
    if (w_yaz1) w_mem[sayac_w_q[AI-1:0]]          <= deger1_i;
    if (w_yaz2) w_mem[sayac_w_q[AI-1:0] + AI'(1)] <= deger2_i;
    if (x_yaz1) x_mem[sayac_x_q[AI-1:0]]          <= deger1_i;
    if (x_yaz2) x_mem[sayac_x_q[AI-1:0] + AI'(1)] <= deger2_i;
  end

  assign sonuc_o  = sonuc_q;
  assign bitti_o  = bitti_q;
  assign w_dolu_o = (sayac_w_q == DOLU);
  assign x_dolu_o = (sayac_x_q == DOLU);

endmodule

// File: tb/tb_yzh_vektor_carpim_birimi.sv
// Directed bench for yzh_vektor_carpim_birimi with a bitti_o-driven scoreboard.
module tb_yzh_vektor_carpim_birimi;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_X  = 3'd1;
  localparam logic [2:0] CLR_W = 3'd2;
  localparam logic [2:0] CLR_X = 3'd3;
  localparam logic [2:0] RUN   = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        durdur = 1'b0;
  logic [2:0]  kontrol = 3'd0;
  logic        basla = 1'b0;
  logic        rs2 = 1'b0;
  logic [31:0] d1 = '0, d2 = '0;
  logic [31:0] sonuc;
  logic        bitti, mesgul, w_dolu, x_dolu;

  int n_chk = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } bek_t;
  bek_t sb[$];

  yzh_vektor_carpim_birimi dut (
    .clk_i(clk), .rst_i(rst), .ddb_durdur_i(durdur), .kontrol_i(kontrol),
    .basla_i(basla), .rs2_en_i(rs2), .deger1_i(d1), .deger2_i(d2),
    .sonuc_o(sonuc), .bitti_o(bitti), .mesgul_o(mesgul),
    .w_dolu_o(w_dolu), .x_dolu_o(x_dolu)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string ad, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", ad, act, exp);
    end
  endtask

  // Monitor: every bitti_o pulse consumes one expected completion.
  always @(negedge clk) begin
    if (!rst && bitti) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_bitti at edge %0d (sonuc 0x%08h)", edge_cnt, sonuc);
      end else begin
        bek_t e;
        e = sb.pop_front();
        chk({e.name, "_sonuc"}, sonuc, e.res);
        chk({e.name, "_gecikme"}, 32'(edge_cnt), 32'(e.due));
      end
    end
  end

  // gec = edges from the accepting edge to the edge that raises bitti_o.
  task automatic komut(input logic [2:0] k, input logic [31:0] a, input logic [31:0] b,
                       input bit r2, input int gec, input logic [31:0] res,
                       input bit beklenir, input string ad);
    bek_t e;
    kontrol = k; d1 = a; d2 = b; rs2 = r2; basla = 1'b1;
    @(posedge clk);
    #1;
    basla = 1'b0; rs2 = 1'b0;
    if (beklenir) begin
      e.res = res; e.due = edge_cnt + gec; e.name = ad;
      sb.push_back(e);
    end
  endtask

  task automatic wait_bos(input bit mesgul_bak);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      if (mesgul_bak && !bitti) chk("mesgul_run", {31'd0, mesgul}, 32'd1);
      #1;
      t++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: %0d completions still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic ld(input logic [2:0] k, input logic [31:0] a, input logic [31:0] b, input bit r2);
    komut(k, a, b, r2, 0, last_res, 1'b1, "komut");
    wait_bos(1'b0);
  endtask

  task automatic run(input logic [31:0] res, input int gec, input string ad);
    komut(RUN, 32'd0, 32'd0, 1'b0, gec, res, 1'b1, ad);
    last_res = res;
    wait_bos(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_sonuc", sonuc, 32'd0);
    chk("reset_bitti", {31'd0, bitti}, 32'd0);
    chk("reset_mesgul", {31'd0, mesgul}, 32'd0);
    chk("reset_w_dolu", {31'd0, w_dolu}, 32'd0);
    chk("reset_x_dolu", {31'd0, x_dolu}, 32'd0);

    // Basic dot product: 100*3 + 5*4
    ld(LD_W, 32'd100, 32'd5, 1'b1);
    ld(LD_X, 32'd3, 32'd4, 1'b1);
    run(32'd320, 5, "run_temel");
    @(negedge clk);
    chk("mesgul_bitti_sonra", {31'd0, mesgul}, 32'd0);

    // Same RUN with a 3-cycle stall mid-HESAPLA
    komut(RUN, 32'd0, 32'd0, 1'b0, 8, 32'd320, 1'b1, "run_durdur");
    @(posedge clk);
    #1 durdur = 1'b1;
    repeat (3) @(posedge clk);
    #1 durdur = 1'b0;
    wait_bos(1'b0);

    // Empty W: result 0 after one edge; then X count becomes 3
    ld(CLR_W, 32'd0, 32'd0, 1'b0);
    run(32'd0, 1, "run_bos");
    ld(LD_X, 32'd7, 32'd0, 1'b0);
    ld(LD_W, 32'd1, 32'd1, 1'b1);
    ld(LD_W, 32'd1, 32'd0, 1'b0);
    run(32'd14, 6, "run_x3");

    // Overflow: 18 W words offered, 16 kept
    ld(CLR_W, 32'd0, 32'd0, 1'b0);
    ld(CLR_X, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 9; i++) ld(LD_W, 32'd1, 32'd1, 1'b1);
    for (int i = 0; i < 8; i++) ld(LD_X, 32'd2, 32'd2, 1'b1);
    chk("w_dolu_tasma", {31'd0, w_dolu}, 32'd1);
    chk("x_dolu_tasma", {31'd0, x_dolu}, 32'd1);
    run(32'd32, 19, "run_dolu");

    // One slot left with rs2_en: first word kept, second dropped
    ld(CLR_X, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 7; i++) ld(LD_X, 32'd2, 32'd2, 1'b1);
    ld(LD_X, 32'd5, 32'd0, 1'b0);
    chk("x_dolu_15", {31'd0, x_dolu}, 32'd0);
    ld(LD_X, 32'd3, 32'd9, 1'b1);
    chk("x_dolu_16", {31'd0, x_dolu}, 32'd1);
    run(32'd36, 19, "run_son_slot");

    // Unknown code: completes, result unchanged
    ld(3'd7, 32'd0, 32'd0, 1'b0);

    // Reset in the middle of a RUN: no completion, everything cleared
    komut(RUN, 32'd0, 32'd0, 1'b0, 0, 32'd0, 1'b0, "run_iptal");
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_run_sonuc", sonuc, 32'd0);
    chk("rst_run_bitti", {31'd0, bitti}, 32'd0);
    chk("rst_run_mesgul", {31'd0, mesgul}, 32'd0);
    chk("rst_run_w_dolu", {31'd0, w_dolu}, 32'd0);
    chk("rst_run_x_dolu", {31'd0, x_dolu}, 32'd0);
    last_res = 32'd0;
    repeat (25) @(negedge clk);
    run(32'd0, 1, "run_rst_sayac");

    // Count mismatch: N = 1
    ld(LD_W, 32'd2, 32'd3, 1'b1);
    ld(LD_W, 32'd4, 32'd0, 1'b0);
    ld(LD_X, 32'd10, 32'd0, 1'b0);
    run(32'd20, 4, "run_uyumsuz");

    // Negative operands: -3*5 + 2*-4 = -23
    ld(CLR_W, 32'd0, 32'd0, 1'b0);
    ld(CLR_X, 32'd0, 32'd0, 1'b0);
    ld(LD_W, 32'hFFFF_FFFD, 32'd2, 1'b1);
    ld(LD_X, 32'd5, 32'hFFFF_FFFC, 1'b1);
    run(32'hFFFF_FFE9, 5, "run_negatif");

    // Largest positive operands
    ld(CLR_W, 32'd0, 32'd0, 1'b0);
    ld(CLR_X, 32'd0, 32'd0, 1'b0);
    ld(LD_W, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    ld(LD_X, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
`ifdef YZH_DOYMA_EN
    run(32'h7FFF_FFFF, 5, "run_sinir");
`else
    run(32'h0000_0002, 5, "run_sinir");
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/yzh_vektor_carpim_birimi.md
Name: yzh_vektor_carpim_birimi

Overview:
- Parametrised successor to the core's AI accelerator.
- Holds separate weight (W) and input (X) buffers of configurable depth, loaded one or two words per command from the rs1/rs2 operands.
- On YZH_RUN, computes the signed dot product of W and X with an internal pipelined multiply-accumulate (MAC), so the shared multiplier is not used.
- Sits in the execute stage beside the multiplier and obeys the pipeline stall (ddb_durdur_i).

Parameters:
- VERI_GENISLIGI, 32, width of buffer entries, operands and sonuc_o.
- DERINLIK, 16, entries per buffer (W and X each); must be a power of two, at least 2.
- CARPMA_GECIKMESI, 2, multiplier pipeline stages; must be at least 1.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- ddb_durdur_i  input  1  pipeline stall; freezes all state.
- kontrol_i  input  3  command: YZH_LD_W, YZH_LD_X, YZH_CLR_W, YZH_CLR_X, YZH_RUN (encodings from tanimlamalar.vh).
- basla_i  input  1  command valid.
- rs2_en_i  input  1  deger2_i also carries data for LD_W/LD_X.
- deger1_i  input  VERI_GENISLIGI  rs1 operand.
- deger2_i  input  VERI_GENISLIGI  rs2 operand.
- sonuc_o  output  VERI_GENISLIGI  last RUN result.
- bitti_o  output  1  one-cycle completion pulse.
- mesgul_o  output  1  RUN in progress; basla_i is ignored while high.
- w_dolu_o  output  1  W count equals DERINLIK.
- x_dolu_o  output  1  X count equals DERINLIK.

Behaviour:
- Only one clock and one reset. rst_i is sampled at the clock edge, is active-high, and reset is synchronous.
- Reset:
  - sonuc_o, bitti_o, mesgul_o, w_dolu_o and x_dolu_o go to 0.
  - Counts sayac_w and sayac_x go to 0; the state machine goes to BOSTA.
  - Buffer contents are don't-care.
  - Reset during RUN aborts it with no bitti_o.
- Accept:
  - A command is accepted at an edge where basla_i=1, ddb_durdur_i=0 and the state is BOSTA.
  - Unknown kontrol_i codes are accepted, have no effect, and produce bitti_o.
- LD_W / LD_X:
  - Writes deger1_i to entry [sayac] and increments sayac.
  - If rs2_en_i=1, also writes deger2_i to entry [sayac+1] in the same cycle; the count rises by 2.
  - Writes beyond DERINLIK are dropped and the count saturates at DERINLIK. With one slot left and rs2_en_i=1, deger1_i is stored and deger2_i is dropped.
  - bitti_o pulses in the cycle after the accepting edge.
- CLR_W / CLR_X:
  - Sets the matching count to 0; the corresponding dolu flag drops.
  - bitti_o pulses in the cycle after the accepting edge.
- RUN:
  - N = min(sayac_w, sayac_x).
  - State machine: BOSTA -> HESAPLA (issues pair i = 0..N-1, one per cycle) -> BOSALT (drains CARPMA_GECIKMESI stages) -> BOSTA.
  - The accumulator starts at 0.
  - Each product is signed VERI_GENISLIGI x VERI_GENISLIGI. Its low VERI_GENISLIGI bits are added with wrap-around.
  - mesgul_o is high from the cycle after acceptance until bitti_o.
  - bitti_o and the new sonuc_o appear together, N+CARPMA_GECIKMESI+1 edges after the accepting edge.
  - If N=0: sonuc_o=0 and bitti_o appears 1 edge after acceptance; the pipeline is skipped.
  - Buffers and counts are unchanged by RUN.
- sonuc_o holds its value until the next RUN completes; loads and clears do not change it.
- bitti_o is high for exactly one unstalled cycle.
- ddb_durdur_i=1:
  - No register changes: counts, buffers, state, pipeline, accumulator, sonuc_o and bitti_o all hold.
  - basla_i is not accepted.
  - Total RUN latency grows by exactly the number of stalled cycles.

Optional Feature:
- Macro: YZH_DOYMA_EN.
- Defined (saturating mode):
  - Full 2*VERI_GENISLIGI signed products are kept.
  - Accumulation uses 2*VERI_GENISLIGI+log2(DERINLIK) bits.
  - The final value is clamped to [-2^(VERI_GENISLIGI-1), 2^(VERI_GENISLIGI-1)-1] before writing sonuc_o.
  - Latency is unchanged.
- Undefined: wrap-around mode as described in Behaviour; the wide accumulator and clamp logic are absent.

Test Plan:
1. Reset; LD_W 100, 5 with rs2_en_i=1; LD_X 3, 4 with rs2_en_i=1; RUN -> sonuc_o=320, bitti_o exactly 5 edges after the RUN accept (N=2, CARPMA_GECIKMESI=2), mesgul_o high in between.
2. After test 1, CLR_W then RUN -> sonuc_o=0, bitti_o 1 edge after accept. LD_X 7 with rs2_en_i=0 -> sayac_x=3.
3. Overflow: 9 LD_W of (1,1) with rs2_en_i=1 (18 words), and 8 LD_X of (2,2) -> w_dolu_o=1, x_dolu_o=1, extra words dropped; RUN -> sonuc_o=32.
4. Count mismatch: W = 2, 3, 4 and X = 10 -> RUN gives sonuc_o=20, latency 1+2+1=4 edges.
5. Stall: during the test 1 RUN, hold ddb_durdur_i=1 for 3 cycles mid-HESAPLA -> same sonuc_o=320, bitti_o at 8 edges.
6. Boundaries:
   - W = X = {0x7FFFFFFF, 0x7FFFFFFF}, RUN -> sonuc_o=0x7FFFFFFF with YZH_DOYMA_EN defined, 0x00000002 without.
   - rst_i asserted mid-RUN -> no bitti_o, all outputs 0, counts 0.
